// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div tracker
// state encoding and the default mult/div occupancy.
package hazard_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int unsigned MULDIV_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks occupancy of the multi-cycle multiply/divide unit after an accepted
// start; busy is high for exactly LATENCY cycles after the accepting edge.
module muldiv_tracker
  import hazard_unit_pkg::*;
#(
  parameter int unsigned LATENCY = MULDIV_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      accept,
  output logic      busy,
  output md_state_t state
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  md_state_t     state_next;
  logic          busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
    end
  end

  // Counter keeps running regardless of pipeline stalls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CW'(LATENCY);
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy_next = (state_next == BUSY);
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use and HI/LO interlocks, memory-wait hold,
// wrong-path squash and a free-running stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter bit          DELAY_SLOT     = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  RegisterRS_IN,
  input  logic [4:0]  RegisterRT_IN,
  input  logic        UsesRS_IN,
  input  logic        UsesRT_IN,
  input  logic        IDEXE_MemRead_IN,
  input  logic        IDEXE_WriteEnable_IN,
  input  logic [4:0]  IDEXE_WriteRegister_IN,
  input  logic        BranchTaken_IN,
  input  logic        MulDivStart_IN,
  input  logic        HILORead_IN,
  input  logic        MemBusy_IN,
  output logic        STALL_IF_OUT,
  output logic        STALL_IFID_OUT,
  output logic        STALL_IDEXE_OUT,
  output logic        STALL_EXEMEM_OUT,
  output logic        STALL_MEMWB_OUT,
  output logic        FLUSH_IFID_OUT,
  output logic        FLUSH_IDEXE_OUT,
  output logic        MulDivBusy_OUT,
  output logic [31:0] StallCount_OUT
);

  logic      load_use;
  logic      hilo_hazard;
  logic      data_hazard;
  logic      accept;
  md_state_t md_state;
  logic [31:0] stall_count;

  assign load_use = IDEXE_MemRead_IN & IDEXE_WriteEnable_IN &
                    (IDEXE_WriteRegister_IN != 5'd0) &
                    ((UsesRS_IN & (RegisterRS_IN == IDEXE_WriteRegister_IN)) |
                     (UsesRT_IN & (RegisterRT_IN == IDEXE_WriteRegister_IN)));

  assign hilo_hazard = (md_state == BUSY) & (HILORead_IN | MulDivStart_IN);
  assign data_hazard = load_use | hilo_hazard;
  assign accept      = MulDivStart_IN & (md_state == IDLE) & ~MemBusy_IN &
                       ~data_hazard & ~RESET;

  muldiv_tracker #(
    .LATENCY(MULDIV_LATENCY)
  ) u_tracker (
    .clk   (CLOCK),
    .reset (RESET),
    .accept(accept),
    .busy  (MulDivBusy_OUT),
    .state (md_state)
  );

  // Priority: reset, memory wait, data hazard, branch squash.
  always_comb begin
    STALL_IF_OUT     = 1'b0;
    STALL_IFID_OUT   = 1'b0;
    STALL_IDEXE_OUT  = 1'b0;
    STALL_EXEMEM_OUT = 1'b0;
    STALL_MEMWB_OUT  = 1'b0;
    FLUSH_IFID_OUT   = 1'b0;
    FLUSH_IDEXE_OUT  = 1'b0;
    if (RESET) begin
      STALL_IF_OUT = 1'b0;
    end else if (MemBusy_IN) begin
      STALL_IF_OUT     = 1'b1;
      STALL_IFID_OUT   = 1'b1;
      STALL_IDEXE_OUT  = 1'b1;
      STALL_EXEMEM_OUT = 1'b1;
      STALL_MEMWB_OUT  = 1'b1;
    end else if (data_hazard) begin
      STALL_IF_OUT    = 1'b1;
      STALL_IFID_OUT  = 1'b1;
      FLUSH_IDEXE_OUT = 1'b1;
    end else if (BranchTaken_IN && !DELAY_SLOT) begin
      FLUSH_IFID_OUT = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_count <= '0;
    end else if (STALL_IF_OUT) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign StallCount_OUT = stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with a 4-cycle mult/div and no delay slot.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic       we;
    logic [4:0] wr;
    logic       br;
    logic       mds;
    logic       hilo;
    logic       mb;
    logic       rst;
  } stim_t;

  // stall = {IF, IFID, IDEXE, EXEMEM, MEMWB}, flush = {IFID, IDEXE}
  typedef struct packed {
    logic [4:0] stall;
    logic [1:0] flush;
    logic       busy;
  } exp_t;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_DH   = 5'b11000;
  localparam logic [4:0] S_ALL  = 5'b11111;
  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_IDEX = 2'b01;
  localparam logic [1:0] F_IFID = 2'b10;

  logic        clk;
  stim_t       s;
  exp_t        obs;
  logic        stall_if, stall_ifid, stall_idexe, stall_exemem, stall_memwb;
  logic        flush_ifid, flush_idexe, md_busy;
  logic [31:0] stall_count;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  hazard_unit #(
    .MULDIV_LATENCY(4),
    .DELAY_SLOT    (1'b0)
  ) dut (
    .CLOCK                 (clk),
    .RESET                 (s.rst),
    .RegisterRS_IN         (s.rs),
    .RegisterRT_IN         (s.rt),
    .UsesRS_IN             (s.urs),
    .UsesRT_IN             (s.urt),
    .IDEXE_MemRead_IN      (s.mr),
    .IDEXE_WriteEnable_IN  (s.we),
    .IDEXE_WriteRegister_IN(s.wr),
    .BranchTaken_IN        (s.br),
    .MulDivStart_IN        (s.mds),
    .HILORead_IN           (s.hilo),
    .MemBusy_IN            (s.mb),
    .STALL_IF_OUT          (stall_if),
    .STALL_IFID_OUT        (stall_ifid),
    .STALL_IDEXE_OUT       (stall_idexe),
    .STALL_EXEMEM_OUT      (stall_exemem),
    .STALL_MEMWB_OUT       (stall_memwb),
    .FLUSH_IFID_OUT        (flush_ifid),
    .FLUSH_IDEXE_OUT       (flush_idexe),
    .MulDivBusy_OUT        (md_busy),
    .StallCount_OUT        (stall_count)
  );

  assign obs = exp_t'({stall_if, stall_ifid, stall_idexe, stall_exemem, stall_memwb,
                       flush_ifid, flush_idexe, md_busy});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t lu(input logic [4:0] r);
    stim_t x;
    x     = '0;
    x.rs  = r;
    x.urs = 1'b1;
    x.mr  = 1'b1;
    x.we  = 1'b1;
    x.wr  = r;
    return x;
  endfunction

  function automatic exp_t mk(input logic [4:0] st, input logic [1:0] fl, input logic b);
    return exp_t'({st, fl, b});
  endfunction

  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    x = lu(5'd8); x.mb = 1'b1; x.br = 1'b1; x.rst = 1'b1;
    st.push_back(x);      ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    st.push_back('0);     ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL reset_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    st.push_back(lu(5'd8)); ex.push_back(mk(S_DH, F_IDEX, 1'b0));
    x = '0; x.rs = 5'd8; x.urs = 1'b1;
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = '0; x.rt = 5'd9; x.urt = 1'b1; x.mr = 1'b1; x.we = 1'b1; x.wr = 5'd9;
    st.push_back(x);        ex.push_back(mk(S_DH, F_IDEX, 1'b0));
    x = lu(5'd0);
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = lu(5'd8); x.urs = 1'b0; x.rs = 5'd3; x.rt = 5'd8; x.urt = 1'b0;
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = lu(5'd8); x.we = 1'b0;
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = lu(5'd8); x.mr = 1'b0;
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    st.push_back('0);       ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL load_use_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    x = lu(5'd8); x.mb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st.push_back(x); ex.push_back(mk(S_ALL, F_NONE, 1'b0));
    end
    st.push_back(lu(5'd8)); ex.push_back(mk(S_DH, F_IDEX, 1'b0));
    x = '0; x.rs = 5'd8; x.urs = 1'b1;
    st.push_back(x);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = '0; x.mds = 1'b1; x.mb = 1'b1;
    st.push_back(x);        ex.push_back(mk(S_ALL, F_NONE, 1'b0));
    st.push_back('0);       ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL mem_wait_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_muldiv();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    x = '0; x.mds = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    x = '0; x.hilo = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_DH, F_IDEX, 1'b1));
    x = '0; x.hilo = 1'b1; x.mb = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_ALL, F_NONE, 1'b1));
    x = '0; x.mds = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_DH, F_IDEX, 1'b1));
    x = '0; x.hilo = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_DH, F_IDEX, 1'b1));
    st.push_back(x);  ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    st.push_back('0); ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL muldiv[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL muldiv_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    x = '0; x.br = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_IFID, 1'b0));
    x = lu(5'd8); x.br = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_DH, F_IDEX, 1'b0));
    x = '0; x.br = 1'b1; x.rs = 5'd8; x.urs = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_IFID, 1'b0));
    x = '0; x.br = 1'b1; x.mb = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_ALL, F_NONE, 1'b0));
    st.push_back('0); ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL branch_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_reset_busy();
    stim_t st[$];
    exp_t  ex[$];
    stim_t x;
    exp_t  e;
    x = '0; x.mds = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    st.push_back('0); ex.push_back(mk(S_NONE, F_NONE, 1'b1));
    x = '0; x.rst = 1'b1; x.mds = 1'b1; x.hilo = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_NONE, 1'b1));
    x = '0; x.hilo = 1'b1;
    st.push_back(x);  ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    st.push_back('0); ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL reset_busy_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    @(posedge clk); #1;
    force dut.stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count;
    exp_cnt = 32'hFFFF_FFFF;
    st.push_back(lu(5'd12)); ex.push_back(mk(S_DH, F_IDEX, 1'b0));
    st.push_back('0);        ex.push_back(mk(S_NONE, F_NONE, 1'b0));
    foreach (st[i]) begin
      @(negedge clk); s = st[i]; exp_q.push_back(ex[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wrap[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=%b busy=%b",
                 i, obs.stall, obs.flush, obs.busy, e.stall, e.flush, e.busy);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got %h want %h", i, stall_count, exp_cnt);
      end
      if (st[i].rst) exp_cnt = '0; else if (e.stall[4]) exp_cnt++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    s       = '0;
    s.rst   = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_muldiv();
    test_branch();
    test_reset_busy();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
